sm83_alu_seq: RTL and testbench
===============================

SM83_ALU_SEQ -- requirements
Module: sm83_alu_seq

Interface
REQ-001 clk  in  1  single clock; all state SHALL change on posedge clk.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  request one 8-bit ALU operation; accepted only when busy=0.
REQ-004 op  in  4  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP, 8 DAA; 9-15 illegal.
REQ-005 flags_in  in  4  current {Z,N,H,C}.
REQ-006 busy  out  1  high in every state except IDLE.
REQ-007 done  out  1  one-cycle completion pulse.
REQ-008 flags_out  out  4  registered {Z,N,H,C}; valid while done=1, held until next start.
REQ-009 res_we  out  1  datapath writes ALU bus result to the destination register.
REQ-010 bus_sel  out  2  ALU din source: 0 operand A, 1 operand B, 2 corr, 3 unused.
REQ-011 corr  out  8  DAA correction constant.
REQ-012 load_a, load_b, op_low, op_b_high, result_oe, negate, carry_in  out  1 each  ALU controls of the same names.
REQ-013 no_carry_out, force_carry, ignore_carry  out  1 each  ALU slice R/S/V controls.
REQ-014 alu_carry, alu_zero, daa_l_gt_9, daa_h_gt_9, daa_h_eq_9  in  1 each  ALU status.

Function
REQ-015 States SHALL be IDLE, LOAD_A, LOAD_B, LOW, HIGH, DONE; start in IDLE moves to LOAD_A, then one state per cycle to DONE, then IDLE.
REQ-016 op and flags_in SHALL be latched at acceptance; start while busy=1 SHALL be ignored.
REQ-017 Latency: start sampled at edge N; done=1 during cycle N+5; a new start is accepted in cycle N+6.
REQ-018 LOAD_A: bus_sel=0, load_a=1; LOAD_B: load_b=1, bus_sel=2 for DAA else 1.
REQ-019 LOW: op_low=1, op_b_high=0; ALU carry SHALL be registered at end of LOW as c_lo.
REQ-020 HIGH: op_low=0, op_b_high=1, carry_in=c_lo, result_oe=1; res_we=1 except for CP; alu_carry (c_hi) and alu_zero SHALL be captured at end of HIGH.
REQ-021 Slice controls for LOW and HIGH: ADD/ADC/SUB/SBC/CP/DAA R=S=V=0; AND R=0,S=1,V=0, LOW carry_in=1; XOR R=1,S=0,V=0, LOW carry_in=0; OR R=1,S=1,V=1, LOW carry_in=0.
REQ-022 LOW carry_in: ADD 0; ADC C; SUB/CP 1; SBC !C; negate=1 for SUB, SBC, CP, and for DAA when N=1.
REQ-023 Flags: Z=captured alu_zero; add ops N=0,H=c_lo,C=c_hi; SUB/SBC/CP N=1,H=!c_lo,C=!c_hi; AND N=0,H=1,C=0; XOR/OR N=0,H=0,C=0.
REQ-024 Illegal op: IDLE->DONE directly (done at N+1), res_we never asserted, flags_out=latched flags_in.
REQ-025 All ALU control outputs, res_we and bus_sel SHALL be 0 in IDLE and DONE.

Reset
REQ-026 Reset in any state, including mid-operation, SHALL force IDLE on the next edge with busy=0, done=0, flags_out=0, corr=0 and all control outputs 0; an interrupted operation SHALL never assert done or res_we.
REQ-027 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro SM83_ALU_SEQ_DAA_EN: when defined, op 8 is DAA; when undefined, op 8 is an illegal op per REQ-024.
REQ-029 DAA, N=0: corr low nibble=6 if H or daa_l_gt_9; corr high nibble=6 if C or daa_h_gt_9 or (daa_h_eq_9 and daa_l_gt_9); operation is an add.
REQ-030 DAA, N=1: corr low nibble=6 if H; corr high nibble=6 if C; operation is a subtract.
REQ-031 DAA flags: Z from result, N unchanged, H=0, C=old C or (N=0 and corr high nibble nonzero).
REQ-032 corr SHALL be computed in LOAD_A from latched flags and ALU status and held through DONE.

Verification
REQ-033 ADD A=0x3A, B=0xC6 -> result 0x00, flags Z1 N0 H1 C1, done exactly 5 cycles after start.
REQ-034 SUB A=0x10, B=0x01 -> result 0x0F, Z0 N1 H1 C0; SBC A=0x10, B=0x0F, C=1 -> 0x00, Z1 N1 H1 C0.
REQ-035 CP A=0x42, B=0x42 -> Z1 N1 H0 C0, res_we low all cycles; AND 0xF0, 0x3C -> 0x30, Z0 N0 H1 C0.
REQ-036 DAA with macro, A=0x9A, flags 0000 -> corr 0x66, result 0x00, Z1 N0 H0 C1; without macro -> done at N+1, flags_out=flags_in.
REQ-037 Reset asserted during LOW -> IDLE next cycle, done/res_we never pulse; start of op 12 -> done at N+1, res_we 0.
REQ-038 start held high continuously -> ops accepted every 6 cycles, no start accepted while busy=1.

Source files
------------

// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: control sequencer for one 8-bit SM83 ALU operation executed
// as two nibble passes (LOW, HIGH) on an external 4-bit ALU slice.
// Optional DAA support is enabled by defining SM83_ALU_SEQ_DAA_EN; without it,
// op 8 is treated as illegal.
// Handshake: start is taken only in IDLE (busy=0). The op finishes with a
// single-cycle done, and flags_out stays valid from done until it is next
// updated.
module sm83_alu_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [3:0] flags_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] flags_out,
  output logic       res_we,
  output logic [1:0] bus_sel,
  output logic [7:0] corr,
  output logic       load_a,
  output logic       load_b,
  output logic       op_low,
  output logic       op_b_high,
  output logic       result_oe,
  output logic       negate,
  output logic       carry_in,
  output logic       no_carry_out,
  output logic       force_carry,
  output logic       ignore_carry,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       daa_l_gt_9,
  input  logic       daa_h_gt_9,
  input  logic       daa_h_eq_9,
  output logic [2:0] state_dbg
);

`ifdef SM83_ALU_SEQ_DAA_EN
  localparam logic DAA_EN = 1'b1;
`else
  localparam logic DAA_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOW, HIGH, DONE} state_t;

  state_t     state, next_state;
  logic [3:0] op_q;
  logic [2:0] nhc_q;      // latched {N,H,C}; Z is never needed as an input
  logic       c_lo;
  logic       op_legal, is_daa, is_sub, low_ci;
  logic [2:0] rsv;
  logic [7:0] corr_calc;
  logic [3:0] flags_next;

  assign state_dbg = state;
  assign op_legal  = (op <= 4'd7) || (DAA_EN && op == 4'd8);
  assign is_daa    = DAA_EN && (op_q == 4'd8);
  assign is_sub    = (op_q == 4'd2) || (op_q == 4'd3) || (op_q == 4'd7) ||
                     (is_daa && nhc_q[2]);

  // Low-nibble carry-in and slice R/S/V controls per operation
  always_comb begin
    low_ci = 1'b0;
    rsv    = 3'b000;
    case (op_q)
      4'd1:       low_ci = nhc_q[0];
      4'd2, 4'd7: low_ci = 1'b1;
      4'd3:       low_ci = ~nhc_q[0];
      4'd4: begin low_ci = 1'b1; rsv = 3'b010; end
      4'd5:       rsv = 3'b100;
      4'd6:       rsv = 3'b111;
      4'd8:       low_ci = nhc_q[2];  // DAA after a subtract is itself a subtract
      default:    low_ci = 1'b0;
    endcase
  end

  // DAA correction constant from latched N/H/C and the ALU nibble status
  always_comb begin
    corr_calc = 8'h00;
    if (nhc_q[2]) begin
      corr_calc[3:0] = nhc_q[1] ? 4'h6 : 4'h0;
      corr_calc[7:4] = nhc_q[0] ? 4'h6 : 4'h0;
    end else begin
      corr_calc[3:0] = (nhc_q[1] || daa_l_gt_9) ? 4'h6 : 4'h0;
      corr_calc[7:4] = (nhc_q[0] || daa_h_gt_9 || (daa_h_eq_9 && daa_l_gt_9)) ? 4'h6 : 4'h0;
    end
  end

  // Final {Z,N,H,C} from HIGH-pass status and the registered low carry
  always_comb begin
    flags_next = {alu_zero, 3'b000};
    case (op_q)
      4'd0, 4'd1:       flags_next = {alu_zero, 1'b0, c_lo, alu_carry};
      4'd2, 4'd3, 4'd7: flags_next = {alu_zero, 1'b1, ~c_lo, ~alu_carry};
      4'd4:             flags_next = {alu_zero, 3'b010};
      4'd8:             flags_next = {alu_zero, nhc_q[2], 1'b0,
                                      nhc_q[0] | (~nhc_q[2] & (corr[7:4] != 4'h0))};
      default:          flags_next = {alu_zero, 3'b000};
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Operand latch, low carry, correction constant and flag result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= 4'd0;
      nhc_q     <= 3'b000;
      c_lo      <= 1'b0;
      corr      <= 8'h00;
      flags_out <= 4'h0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          nhc_q <= flags_in[2:0];
          corr  <= 8'h00;
          if (!op_legal) flags_out <= flags_in;
        end
        LOAD_A: if (is_daa) corr <= corr_calc;
        LOW:    c_lo <= alu_carry;
        HIGH:   flags_out <= flags_next;
        default: ;
      endcase
    end
  end

  // Next-state and per-state ALU control decode
  always_comb begin
    next_state   = state;
    busy         = (state != IDLE);
    done         = (state == DONE);
    res_we       = 1'b0;
    bus_sel      = 2'd0;
    load_a       = 1'b0;
    load_b       = 1'b0;
    op_low       = 1'b0;
    op_b_high    = 1'b0;
    result_oe    = 1'b0;
    negate       = 1'b0;
    carry_in     = 1'b0;
    no_carry_out = 1'b0;
    force_carry  = 1'b0;
    ignore_carry = 1'b0;
    case (state)
      IDLE: if (start) next_state = op_legal ? LOAD_A : DONE;
      LOAD_A: begin
        load_a     = 1'b1;
        next_state = LOAD_B;
      end
      LOAD_B: begin
        load_b     = 1'b1;
        bus_sel    = is_daa ? 2'd2 : 2'd1;
        next_state = LOW;
      end
      LOW: begin
        op_low     = 1'b1;
        negate     = is_sub;
        carry_in   = low_ci;
        {no_carry_out, force_carry, ignore_carry} = rsv;
        next_state = HIGH;
      end
      HIGH: begin
        op_b_high  = 1'b1;
        result_oe  = 1'b1;
        res_we     = (op_q != 4'd7);
        negate     = is_sub;
        carry_in   = c_lo;
        {no_carry_out, force_carry, ignore_carry} = rsv;
        next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sm83_alu_seq.sv
// tb_sm83_alu_seq: directed-vector bench for sm83_alu_seq. The ALU slice is
// stood in for by per-vector carry/zero values presented only in the pass
// (LOW or HIGH) where the sequencer is expected to sample them.
module tb_sm83_alu_seq;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] op, flags_in;
  logic       busy, done, res_we;
  logic [3:0] flags_out;
  logic [1:0] bus_sel;
  logic [7:0] corr;
  logic       load_a, load_b, op_low, op_b_high, result_oe, negate, carry_in;
  logic       no_carry_out, force_carry, ignore_carry;
  logic       alu_carry, alu_zero, daa_l_gt_9, daa_h_gt_9, daa_h_eq_9;
  logic [2:0] state_dbg;

  typedef struct {
    logic [3:0] op;
    logic [3:0] fin;
    logic       c_lo, c_hi, zero, l9, h9, he9;
    logic [3:0] ef;
    logic       eci;
    logic [2:0] rsv;
    logic       neg;
    logic [1:0] bsel;
    logic [7:0] corr;
    logic       legal;
    logic       we;
  } vec_t;

  vec_t cur;
  vec_t vecs[11];
  int   tests = 0;
  int   fails = 0;

  wire [12:0] ctrl = {res_we, bus_sel, load_a, load_b, op_low, op_b_high, result_oe,
                      negate, carry_in, no_carry_out, force_carry, ignore_carry};

  // ALU stand-in: carry only during the pass being sampled, zero only in HIGH
  assign alu_carry  = op_low ? cur.c_lo : (op_b_high ? cur.c_hi : 1'b0);
  assign alu_zero   = op_b_high ? cur.zero : 1'b0;
  assign daa_l_gt_9 = cur.l9;
  assign daa_h_gt_9 = cur.h9;
  assign daa_h_eq_9 = cur.he9;

  sm83_alu_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .flags_in(flags_in),
    .busy(busy), .done(done), .flags_out(flags_out), .res_we(res_we),
    .bus_sel(bus_sel), .corr(corr), .load_a(load_a), .load_b(load_b),
    .op_low(op_low), .op_b_high(op_b_high), .result_oe(result_oe),
    .negate(negate), .carry_in(carry_in), .no_carry_out(no_carry_out),
    .force_carry(force_carry), .ignore_carry(ignore_carry),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .daa_l_gt_9(daa_l_gt_9),
    .daa_h_gt_9(daa_h_gt_9), .daa_h_eq_9(daa_h_eq_9), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op and check each state of its sequence
  task automatic run_vec(input vec_t v, input string name);
    int done_k = 0;
    int done_n = 0;
    int we_n   = 0;
    cur = v;
    @(negedge clk);
    start = 1'b1; op = v.op; flags_in = v.fin;
    @(posedge clk); #1;
    start = 1'b0; op = 4'hF; flags_in = ~v.fin;  // proves inputs were latched
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (res_we) we_n++;
      if (done) begin
        done_n++;
        if (done_k == 0) done_k = k;
        check_eq({name, " flags"}, {28'd0, flags_out}, {28'd0, v.ef});
        check_eq({name, " corr"}, {24'd0, corr}, {24'd0, v.corr});
        check_eq({name, " ctrl_in_done"}, {19'd0, ctrl}, 32'd0);
      end
      if (v.legal) begin
        if (k == 1) check_eq({name, " load_a"}, {29'd0, busy, load_a, bus_sel == 2'd0}, 32'h7);
        if (k == 2) check_eq({name, " load_b"}, {29'd0, load_b, bus_sel}, {29'd0, 1'b1, v.bsel});
        if (k == 3) check_eq({name, " low"},
                             {25'd0, op_low, op_b_high, carry_in, negate, no_carry_out, force_carry, ignore_carry},
                             {25'd0, 1'b1, 1'b0, v.eci, v.neg, v.rsv});
        if (k == 4) check_eq({name, " high"},
                             {25'd0, op_b_high, carry_in, result_oe, res_we, negate, no_carry_out, force_carry, ignore_carry} | {24'd0, op_low, 7'd0},
                             {25'd0, 1'b1, v.c_lo, 1'b1, v.we, v.neg, v.rsv});
      end
    end
    check_eq({name, " done_cycle"}, done_k, v.legal ? 32'd5 : 32'd1);
    check_eq({name, " done_count"}, done_n, 32'd1);
    check_eq({name, " res_we_count"}, we_n, (v.legal && v.we) ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [11:0] busy_pat, done_pat;
    int          bad_n;
    // op fin clo chi z l9 h9 he9 ef eci rsv neg bsel corr legal we
    vecs[0] = '{4'd0, 4'h0, 1, 1, 1, 0, 0, 0, 4'b1011, 0, 3'b000, 0, 2'd1, 8'h00, 1, 1}; // ADD 3A+C6
    vecs[1] = '{4'd2, 4'h0, 0, 1, 0, 0, 0, 0, 4'b0110, 1, 3'b000, 1, 2'd1, 8'h00, 1, 1}; // SUB 10-01
    vecs[2] = '{4'd3, 4'h1, 0, 1, 1, 0, 0, 0, 4'b1110, 0, 3'b000, 1, 2'd1, 8'h00, 1, 1}; // SBC 10-0F-1
    vecs[3] = '{4'd7, 4'h0, 1, 1, 1, 0, 0, 0, 4'b1100, 1, 3'b000, 1, 2'd1, 8'h00, 1, 0}; // CP 42,42
    vecs[4] = '{4'd4, 4'h0, 0, 0, 0, 0, 0, 0, 4'b0010, 1, 3'b010, 0, 2'd1, 8'h00, 1, 1}; // AND F0,3C
    vecs[5] = '{4'd5, 4'h0, 0, 0, 1, 0, 0, 0, 4'b1000, 0, 3'b100, 0, 2'd1, 8'h00, 1, 1}; // XOR
    vecs[6] = '{4'd6, 4'hF, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 3'b111, 0, 2'd1, 8'h00, 1, 1}; // OR
    vecs[7] = '{4'd1, 4'h1, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 3'b000, 0, 2'd1, 8'h00, 1, 1}; // ADC C=1
`ifdef SM83_ALU_SEQ_DAA_EN
    vecs[8] = '{4'd8, 4'h0, 1, 1, 1, 1, 0, 1, 4'b1001, 0, 3'b000, 0, 2'd2, 8'h66, 1, 1}; // DAA 9A
    vecs[9] = '{4'd8, 4'h6, 1, 1, 0, 0, 0, 0, 4'b0100, 1, 3'b000, 1, 2'd2, 8'h06, 1, 1}; // DAA N=1,H=1
`else
    vecs[8] = '{4'd8, 4'h0, 1, 1, 1, 1, 0, 1, 4'b0000, 0, 3'b000, 0, 2'd0, 8'h00, 0, 0};
    vecs[9] = '{4'd8, 4'h6, 1, 1, 0, 0, 0, 0, 4'b0110, 0, 3'b000, 0, 2'd0, 8'h00, 0, 0};
`endif
    vecs[10] = '{4'd12, 4'hA, 1, 1, 1, 0, 0, 0, 4'b1010, 0, 3'b000, 0, 2'd0, 8'h00, 0, 0}; // illegal

    // Reset block
    cur = vecs[0];
    reset = 1'b1; start = 1'b0; op = 4'd0; flags_in = 4'h0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", {16'd0, busy, done, flags_out, corr, 2'd0}, 32'd0);
    check_eq("reset_ctrl", {19'd0, ctrl}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset during LOW, with start also high: reset wins, nothing completes
    run_vec(vecs[0], "pre_reset_add");
    cur = vecs[0];
    @(negedge clk);
    start = 1'b1; op = 4'd0; flags_in = 4'h0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_op_in_low", {31'd0, op_low}, 32'd1);
    reset = 1'b1; start = 1'b1;
    bad_n = 0;
    @(negedge clk);
    if (done || res_we) bad_n++;
    check_eq("mid_reset_state", {16'd0, busy, done, flags_out, corr, 2'd0}, 32'd0);
    check_eq("mid_reset_ctrl", {19'd0, ctrl}, 32'd0);
    @(negedge clk);
    check_eq("reset_over_start", {31'd0, busy}, 32'd0);
    reset = 1'b0; start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || res_we || busy) bad_n++;
    end
    check_eq("no_done_after_reset", bad_n, 32'd0);

    // Start held high: one acceptance per six cycles
    cur = vecs[0];
    busy_pat = '0; done_pat = '0;
    @(negedge clk);
    start = 1'b1; op = 4'd0; flags_in = 4'h0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      busy_pat[k-1] = busy;
      done_pat[k-1] = done;
    end
    start = 1'b0;
    check_eq("held_start_busy", {20'd0, busy_pat}, 32'h7DF);
    check_eq("held_start_done", {20'd0, done_pat}, 32'h410);
    repeat (8) @(negedge clk);
    check_eq("held_start_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
